alu_muldiv_unit: RTL



---
 rtl/alu_muldiv_unit.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU: ALUControl decode, single-cycle ops, and an iterative
// shift-add multiplier / restoring divider that writes HI/LO.
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [3:0]       ALUop,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic             Issue,
  output logic [3:0]       ALUCtrl,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  // state | meaning
  // IDLE  | no operation in flight, new mul/div accepted
  // RUN   | one multiply/divide step per cycle, counter counts down
  // FIN   | sign fix-up, HI/LO written at the end of this cycle
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SLL  = 4'b0011;
  localparam logic [3:0] C_SRL  = 4'b0100;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_MFHI = 4'b1100;
  localparam logic [3:0] C_MFLO = 4'b1101;
  localparam logic [3:0] C_NONE = 4'b1111;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 is_md, is_mf, start;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift, div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;

  always_comb begin
    ALUCtrl = ALUop;
    if (ALUop == 4'b1111) begin
      unique case (FuncCode)
        6'b000000: ALUCtrl = C_SLL;
        6'b000010: ALUCtrl = C_SRL;
        6'b100000: ALUCtrl = C_ADD;
        6'b100010: ALUCtrl = C_SUB;
        6'b100100: ALUCtrl = C_AND;
        6'b100101: ALUCtrl = C_OR;
        6'b101010: ALUCtrl = C_SLT;
        6'b011000: ALUCtrl = 4'b1000;
        6'b011001: ALUCtrl = 4'b1001;
        6'b011010: ALUCtrl = 4'b1010;
        6'b011011: ALUCtrl = 4'b1011;
        6'b010000: ALUCtrl = C_MFHI;
        6'b010010: ALUCtrl = C_MFLO;
        default:   ALUCtrl = C_NONE;
      endcase
    end
  end

  always_comb begin
    BusW = '0;
    unique case (ALUCtrl)
      C_AND:   BusW = BusA & BusB;
      C_OR:    BusW = BusA | BusB;
      C_ADD:   BusW = BusA + BusB;
      C_SUB:   BusW = BusA - BusB;
      C_SLT:   BusW = {{(WIDTH-1){1'b0}}, ($signed(BusA) < $signed(BusB))};
      C_SLL:   BusW = BusB << BusA[SHW-1:0];
      C_SRL:   BusW = BusB >> BusA[SHW-1:0];
      C_MFHI:  BusW = hi_q;
      C_MFLO:  BusW = lo_q;
      default: BusW = '0;
    endcase
  end

  assign Zero  = (BusW == '0);
  assign is_md = (ALUCtrl[3:2] == 2'b10);
  assign is_mf = (ALUCtrl == C_MFHI) || (ALUCtrl == C_MFLO);
  assign start = Issue && is_md && (state_q == S_IDLE);

  // MULT/DIV have bit 0 clear and work on magnitudes
  assign a_neg = !ALUCtrl[0] && BusA[WIDTH-1];
  assign b_neg = !ALUCtrl[0] && BusB[WIDTH-1];
  assign mag_a = a_neg ? -BusA : BusA;
  assign mag_b = b_neg ? -BusB : BusB;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ok    = !div_diff[WIDTH];
  assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ok};
  assign prod_fix  = neg_q ? -acc_q : acc_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy  = (state_q != S_IDLE);
    Done  = done_q;
    Stall = Issue && Busy && (is_md || is_mf);
  end

  always_comb begin
    acc_d  = acc_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = (state_q == S_FIN);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d  = {{WIDTH{1'b0}}, mag_a};
          b_d    = mag_b;
          cnt_d  = CW'(WIDTH - 1);
          div_d  = ALUCtrl[1];
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          dz_d   = (BusB == '0);
        end
      end
      S_RUN: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
      end
      S_FIN: begin
        if (div_q) begin
          // divide by zero: remainder already equals the dividend magnitude
          lo_d = dz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      acc_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      done_q <= done_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule
